event_priority_encoder: RTL and testbench
=========================================

Name: event_priority_encoder

Overview:
- Sequential 8-to-3 priority encoder. It is the encode-side counterpart of the 3-to-8 line decoder.
- Captures event pulses on 8 request lines into a pending register.
- Drains pending events one at a time, highest index first, as a 3-bit code over a valid/ready handshake.
- Sits between interrupt/event sources and a consumer that expects a binary line number.

Parameters:
- N, 8, number of request lines. Must be a power of two, 2..256.
- CW, $clog2(N), code width (3 at default). Derived; not overridden.

Ports:
- Clock, input, 1, rising-edge clock.
- Reset, input, 1, asynchronous, active-high reset.
- Enable, input, 1, when 1, Req is captured; when 0, Req is ignored while pending events continue to drain.
- Req, input, N, event request lines, sampled every Clock edge (level = one event per cycle high).
- Ready, input, 1, consumer accepts Code when Valid & Ready at a Clock edge.
- ClearOvf, input, 1, synchronous clear of Overflow.
- Valid, output, 1, Code holds an event.
- Code, output, CW, binary index of the presented event.
- Pending, output, N, current pending register (debug/status).
- Overflow, output, 1, sticky: an event was lost.

Behaviour:
- Reset (async, any time, including mid-handshake) forces:
  - Pending = 0, Valid = 0, Code = 0, Overflow = 0.
  - Deassertion takes effect at the next Clock edge; no events are captured while Reset = 1.
- Capture set mask S = Req & {N{Enable}}.
- Slot free F = !Valid | Ready.
- Selection, evaluated from the registered Pending only (incoming Req is not a candidate):
  - If F and Pending != 0, select k = highest set index of Pending.
  - Otherwise there is no selection.
- Clear mask C = one-hot(k) when a selection occurs, else 0.
- Next-state updates at each Clock edge:
  - Pending <= (Pending & ~C) | S. Set wins over clear: a Req on bit k in the same cycle bit k is selected re-pends it, and this is not an overflow.
  - If a selection occurs: Valid <= 1, Code <= k.
  - Else if Valid & Ready: Valid <= 0, Code holds its last value.
  - Else: Valid and Code hold.
- Valid & !Ready: Code and Valid remain stable until accepted, regardless of new higher-priority requests.
- Overflow:
  - Set if any bit i has S[i] & Pending[i] & !C[i], meaning a duplicate event was lost.
  - ClearOvf = 1 clears it; if a set condition occurs in the same cycle, set wins.
- Latency:
  - Req high before edge t gives Pending set after t.
  - If the slot is free and the request is highest priority, Valid/Code appear after edge t+1.
  - Back-to-back throughput with Ready held 1: one code per cycle.
- Enable = 0 blocks capture only; the handshake and drain are unaffected.
- All outputs are registered; there is no combinational path from Req/Ready to Valid/Code.

Decomposition:
- Shared package holds:
  - N default (8).
  - A function prio_index(vec) returning the highest set index and a found flag.
  - A function onehot(idx). The line decoder reuses this function.
- One natural sub-module: prio_find (combinational, N -> CW + found). Instantiated once for the selection logic.
- Everything else lives in the top-level module.

Test Plan:
1. Reset mid-handshake: hold Valid = 1, Code = 5, Ready = 0, Pending = 8'b0000_0100, then pulse Reset. Immediately after: Valid = 0, Code = 0, Pending = 0, Overflow = 0. First edge after release with Req = 0: still all zero.
2. Single event: Enable = 1, Req = 8'b0001_0000 for one cycle, Ready = 1.
   - Pending = 8'b0001_0000 after edge t.
   - Valid = 1, Code = 3'b100, Pending = 0 after edge t+1.
   - Valid = 0 after edge t+2.
3. Priority and drain: Req = 8'b1000_0101 for one cycle, Ready = 1. Codes 7, 2, 0 appear on consecutive cycles; Valid then drops; Overflow = 0.
4. Backpressure: Req = 8'b0000_0010, Ready = 0 until Valid, then Req = 8'b0100_0000 for one cycle.
   - Code stays 1 while Ready = 0.
   - Raise Ready: Code 1 is accepted, next Code = 6.
5. Overflow and set-wins:
   - Ready = 0, Valid holding code 3; Req = 8'b0000_0001 for two consecutive cycles sets Overflow = 1.
   - ClearOvf = 1 with no duplicate clears it.
   - Req on bit k in the cycle k is selected: Pending[k] stays 1, Overflow stays 0.
6. Enable gating: Enable = 0, Req = 8'hFF gives Pending unchanged and no Valid. Existing pending events still drain with Ready = 1.

Source files
------------

// File: rtl/event_priority_encoder_pkg.sv
// Shared types and helpers for the event priority encoder and its decoder sibling.
//   prio_index(vec): highest set index of vec plus a found flag.
//   onehot(idx)    : one-hot vector with bit idx set.
// Both operate on MAX_N-wide vectors. Callers zero-extend their operand
// and truncate the result, so any N up to MAX_N can share them.
package event_priority_encoder_pkg;

    localparam int unsigned EPE_N = 8;
    localparam int unsigned MAX_N = 256;
    localparam int unsigned IW    = 8;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] idx;
    } prio_t;

    // Later (higher) set bits overwrite earlier ones, so the highest index wins
    function automatic prio_t prio_index(input logic [MAX_N-1:0] vec);
        prio_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = IW'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input logic [IW-1:0] idx);
        logic [MAX_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/event_priority_encoder_if.sv
// Request/handshake bundle for the event priority encoder.
//   master: drives enable, req, ready, clear_ovf; observes valid, code, pending, overflow
//   slave : the encoder side
interface event_priority_encoder_if #(
    parameter int unsigned N = event_priority_encoder_pkg::EPE_N
);
    import event_priority_encoder_pkg::*;

    localparam int unsigned CW = $clog2(N);

    logic          enable;
    logic [N-1:0]  req;
    logic          ready;
    logic          clear_ovf;
    logic          valid;
    logic [CW-1:0] code;
    logic [N-1:0]  pending;
    logic          overflow;

    modport master (
        output enable, req, ready, clear_ovf,
        input  valid, code, pending, overflow
    );

    modport slave (
        input  enable, req, ready, clear_ovf,
        output valid, code, pending, overflow
    );

endinterface

// File: rtl/event_priority_encoder_prio_find.sv
// Combinational highest-set-bit finder.
//   vec     : candidate vector (N bits)
//   idx_c   : index of the highest set bit (0 when none set)
//   found_c : 1 when any bit of vec is set
module event_priority_encoder_prio_find
    import event_priority_encoder_pkg::*;
#(
    parameter int unsigned N = EPE_N
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 found_c
);

    localparam int unsigned CW = $clog2(N);

    prio_t res;

    always_comb begin
        res     = prio_index(MAX_N'(vec));
        idx_c   = CW'(res.idx);
        found_c = res.found;
    end

endmodule

// File: rtl/event_priority_encoder.sv
// Sequential N-to-log2(N) priority encoder with event capture.
// Request pulses accumulate in a pending register. Pending events drain one
// per accepted handshake, highest index first, as a binary code.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of event_priority_encoder_if
//              (enable/req/ready/clear_ovf in; valid/code/pending/overflow out)
// N must be a power of two in 2..256.
module event_priority_encoder
    import event_priority_encoder_pkg::*;
#(
    parameter int unsigned N = EPE_N
) (
    input  logic                    clk,
    input  logic                    rst,
    event_priority_encoder_if.slave bus
);

    localparam int unsigned CW = $clog2(N);

    logic [N-1:0]  pending_q, pending_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] code_q, code_d;
    logic          overflow_q, overflow_d;

    logic [N-1:0]  set_mask;
    logic [N-1:0]  clr_mask;
    logic [CW-1:0] sel_idx;
    logic          sel_found;
    logic          slot_free;
    logic          sel;

    // Selection sees only registered pending, never this cycle's req
    event_priority_encoder_prio_find #(.N(N)) u_prio_find (
        .vec     (pending_q),
        .idx_c   (sel_idx),
        .found_c (sel_found)
    );

    // Next-state: capture, select/clear, handshake and overflow tracking
    always_comb begin
        set_mask   = '0;
        clr_mask   = '0;
        slot_free  = 1'b0;
        sel        = 1'b0;
        pending_d  = pending_q;
        valid_d    = valid_q;
        code_d     = code_q;
        overflow_d = overflow_q;

        set_mask  = bus.req & {N{bus.enable}};
        slot_free = !valid_q || bus.ready;
        sel       = slot_free && sel_found;

        if (sel) begin
            clr_mask = N'(onehot(IW'(sel_idx)));
        end

        // Set after clear: a req on the bit being selected re-pends it
        pending_d = (pending_q & ~clr_mask) | set_mask;

        if (sel) begin
            valid_d = 1'b1;
            code_d  = sel_idx;
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        // A duplicate only counts as lost if the bit is not leaving this cycle
        if (|(set_mask & pending_q & ~clr_mask)) begin
            overflow_d = 1'b1;
        end else if (bus.clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.pending  = pending_q;
    assign bus.valid    = valid_q;
    assign bus.code     = code_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_event_priority_encoder.sv
// Self-checking bench for event_priority_encoder (N = 8).
// Expected codes are queued when requests are driven and popped on each
// accepted handshake.
module tb_event_priority_encoder;

    logic clk;
    logic rst;

    event_priority_encoder_if #(.N(8)) bus ();

    event_priority_encoder #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned vectors;
    int unsigned miscompares;
    logic [2:0]  exp_q[$];
    logic [2:0]  exp_code;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.req       = '0;
        bus.ready     = 1'b0;
        bus.clear_ovf = 1'b0;
        repeat (2) tick();
        vectors += 4;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL reset_code got %0d want 0", bus.code); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending got %h want 00", bus.pending); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        rst = 1'b0;
        // Build Valid=1/Code=5/Pending=0000_0100 with the consumer stalled
        bus.enable = 1'b1;
        bus.req    = 8'h24;
        tick();
        bus.req = '0;
        tick();
        vectors += 3;
        if (bus.valid !== 1'b1 || bus.code !== 3'd5) begin miscompares++; $display("FAIL pre_reset_hold got v=%b c=%0d want v=1 c=5", bus.valid, bus.code); end
        if (bus.pending !== 8'h04) begin miscompares++; $display("FAIL pre_reset_pending got %h want 04", bus.pending); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL pre_reset_ovf got %b want 0", bus.overflow); end
        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        vectors += 4;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid got %b want 0", bus.valid); end
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL async_rst_code got %0d want 0", bus.code); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL async_rst_pending got %h want 00", bus.pending); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL async_rst_ovf got %b want 0", bus.overflow); end
        tick();
        rst = 1'b0;
        tick();
        vectors += 4;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL post_rel_valid got %b want 0", bus.valid); end
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL post_rel_code got %0d want 0", bus.code); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL post_rel_pending got %h want 00", bus.pending); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL post_rel_ovf got %b want 0", bus.overflow); end
    endtask

    task automatic test_single();
        bus.enable = 1'b1;
        bus.ready  = 1'b1;
        bus.req    = 8'h10;
        exp_q.push_back(3'd4);
        tick();
        bus.req = '0;
        vectors += 2;
        if (bus.pending !== 8'h10) begin miscompares++; $display("FAIL single_capture got %h want 10", bus.pending); end
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", bus.valid); end
        tick();
        vectors += 2;
        if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", bus.valid); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL single_pending_clr got %h want 00", bus.pending); end
        if (bus.valid && bus.ready) begin
            exp_code = exp_q.pop_front();
            vectors++;
            if (bus.code !== exp_code) begin miscompares++; $display("FAIL single_code got %0d want %0d", bus.code, exp_code); end
        end
        tick();
        vectors++;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop got %b want 0", bus.valid); end
    endtask

    task automatic test_priority();
        int streak;
        int max_streak;
        streak     = 0;
        max_streak = 0;
        bus.ready  = 1'b1;
        bus.req    = 8'h85;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        tick();
        bus.req = '0;
        vectors++;
        if (bus.pending !== 8'h85) begin miscompares++; $display("FAIL prio_capture got %h want 85", bus.pending); end
        for (int c = 0; c < 12 && (exp_q.size() != 0 || bus.valid); c++) begin
            if (bus.valid && bus.ready) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL prio_extra_code got %0d want none", bus.code);
                end else begin
                    exp_code = exp_q.pop_front();
                    vectors++;
                    if (bus.code !== exp_code) begin miscompares++; $display("FAIL prio_code got %0d want %0d", bus.code, exp_code); end
                end
            end else begin
                streak = 0;
            end
            tick();
        end
        vectors += 3;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL prio_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        if (max_streak != 3) begin miscompares++; $display("FAIL prio_streak got %0d want 3", max_streak); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL prio_ovf got %b want 0", bus.overflow); end
    endtask

    task automatic test_backpressure();
        bus.ready = 1'b0;
        bus.req   = 8'h02;
        exp_q.push_back(3'd1);
        tick();
        bus.req = '0;
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd1) begin miscompares++; $display("FAIL bp_first got v=%b c=%0d want v=1 c=1", bus.valid, bus.code); end
        bus.req = 8'h40;
        exp_q.push_back(3'd6);
        tick();
        bus.req = '0;
        vectors++;
        if (bus.pending !== 8'h40) begin miscompares++; $display("FAIL bp_pending got %h want 40", bus.pending); end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.valid !== 1'b1 || bus.code !== 3'd1) begin miscompares++; $display("FAIL bp_hold got v=%b c=%0d want v=1 c=1", bus.valid, bus.code); end
            tick();
        end
        bus.ready = 1'b1;
        for (int c = 0; c < 10 && (exp_q.size() != 0 || bus.valid); c++) begin
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL bp_extra_code got %0d want none", bus.code);
                end else begin
                    exp_code = exp_q.pop_front();
                    vectors++;
                    if (bus.code !== exp_code) begin miscompares++; $display("FAIL bp_code got %0d want %0d", bus.code, exp_code); end
                end
            end
            tick();
        end
        vectors += 2;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL bp_pending_end got %h want 00", bus.pending); end
    endtask

    task automatic test_overflow();
        bus.ready = 1'b0;
        bus.req   = 8'h08;
        exp_q.push_back(3'd3);
        tick();
        bus.req = '0;
        tick();
        vectors++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd3) begin miscompares++; $display("FAIL ovf_setup got v=%b c=%0d want v=1 c=3", bus.valid, bus.code); end
        bus.req = 8'h01;
        tick();
        vectors += 2;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_first_req got %b want 0", bus.overflow); end
        if (bus.pending !== 8'h01) begin miscompares++; $display("FAIL ovf_pending got %h want 01", bus.pending); end
        tick();
        bus.req = '0;
        vectors += 2;
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_dup got %b want 1", bus.overflow); end
        if (bus.pending !== 8'h01) begin miscompares++; $display("FAIL ovf_pending_dup got %h want 01", bus.pending); end
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
        // Bit 0 is selected on the same edge it is requested again
        bus.ready = 1'b1;
        bus.req   = 8'h01;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        if (bus.valid && bus.ready) begin
            exp_code = exp_q.pop_front();
            vectors++;
            if (bus.code !== exp_code) begin miscompares++; $display("FAIL ovf_accept got %0d want %0d", bus.code, exp_code); end
        end
        tick();
        bus.req = '0;
        vectors += 2;
        if (bus.pending !== 8'h01) begin miscompares++; $display("FAIL setwins_pending got %h want 01", bus.pending); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL setwins_ovf got %b want 0", bus.overflow); end
        for (int c = 0; c < 10 && (exp_q.size() != 0 || bus.valid); c++) begin
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL ovf_extra_code got %0d want none", bus.code);
                end else begin
                    exp_code = exp_q.pop_front();
                    vectors++;
                    if (bus.code !== exp_code) begin miscompares++; $display("FAIL ovf_code got %0d want %0d", bus.code, exp_code); end
                end
            end
            tick();
        end
        vectors += 2;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovf_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        if (bus.pending !== 8'h00) begin miscompares++; $display("FAIL ovf_pending_end got %h want 00", bus.pending); end
    endtask

    task automatic test_enable();
        bus.ready  = 1'b0;
        bus.enable = 1'b1;
        bus.req    = 8'h18;
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd3);
        tick();
        bus.req = '0;
        tick();
        vectors += 2;
        if (bus.valid !== 1'b1 || bus.code !== 3'd4) begin miscompares++; $display("FAIL en_setup got v=%b c=%0d want v=1 c=4", bus.valid, bus.code); end
        if (bus.pending !== 8'h08) begin miscompares++; $display("FAIL en_setup_pending got %h want 08", bus.pending); end
        bus.enable = 1'b0;
        bus.req    = 8'hFF;
        tick();
        vectors += 3;
        if (bus.pending !== 8'h08) begin miscompares++; $display("FAIL en_gate_pending got %h want 08", bus.pending); end
        if (bus.valid !== 1'b1 || bus.code !== 3'd4) begin miscompares++; $display("FAIL en_gate_hold got v=%b c=%0d want v=1 c=4", bus.valid, bus.code); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL en_gate_ovf got %b want 0", bus.overflow); end
        bus.ready = 1'b1;
        for (int c = 0; c < 10 && (exp_q.size() != 0 || bus.valid); c++) begin
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL en_extra_code got %0d want none", bus.code);
                end else begin
                    exp_code = exp_q.pop_front();
                    vectors++;
                    if (bus.code !== exp_code) begin miscompares++; $display("FAIL en_code got %0d want %0d", bus.code, exp_code); end
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL en_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin miscompares++; $display("FAIL en_idle got v=%b p=%h want v=0 p=00", bus.valid, bus.pending); end
            tick();
        end
        bus.req    = '0;
        bus.enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        int streak;
        int max_streak;
        streak     = 0;
        max_streak = 0;
        bus.ready  = 1'b1;
        bus.req    = 8'hFF;
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        tick();
        bus.req = '0;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.valid); c++) begin
            if (bus.valid && bus.ready) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b2b_extra_code got %0d want none", bus.code);
                end else begin
                    exp_code = exp_q.pop_front();
                    vectors++;
                    if (bus.code !== exp_code) begin miscompares++; $display("FAIL b2b_code got %0d want %0d", bus.code, exp_code); end
                end
            end else begin
                streak = 0;
            end
            tick();
        end
        vectors += 3;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        if (max_streak != 8) begin miscompares++; $display("FAIL b2b_streak got %0d want 8", max_streak); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf got %b want 0", bus.overflow); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_overflow();
        test_enable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
